// File: rtl/vita49_packer.sv
`default_nettype none
// =============================================================================
// vita49_packer: frames a raw 64-bit sample stream into VITA49 IF Data packets.
// Define VITA49_PACKER_TSF_EN for a sample-count timestamp beat.  Rev 1.0
// =============================================================================
module vita49_packer #(
  parameter int LEN_W = 12
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             cfg_enable,
  input  logic [31:0]      cfg_strm_id,
  input  logic [LEN_W-1:0] cfg_payload_len,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [63:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic [7:0]       M_AXIS_TSTRB,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  output logic [31:0]      stat_pkts,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
`ifdef VITA49_PACKER_TSF_EN
    TS      = 2'd3,
`endif
    PAYLOAD = 2'd2
  } state_t;

`ifdef VITA49_PACKER_TSF_EN
  localparam logic [1:0]  TSF      = 2'b01;
  localparam logic [15:0] HDR_WRDS = 16'd4;
`else
  localparam logic [1:0]  TSF      = 2'b00;
  localparam logic [15:0] HDR_WRDS = 16'd2;
`endif

  state_t           state_q;
  logic [31:0]      strm_id_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [3:0]       pkt_cnt_q;
  logic [31:0]      stat_q;
  logic [63:0]      tdata_q;
  logic             tvalid_q;
  logic             tlast_q;
`ifdef VITA49_PACKER_TSF_EN
  logic [63:0]      samp_cnt_q;
  logic [63:0]      ts_q;
`endif

  logic [LEN_W-1:0] len_d;
  logic             out_free;
  logic             in_fire;
  logic             last_beat;
  logic [15:0]      pkt_size;
  logic [63:0]      hdr_word;
  logic             unused_tlast;

  // Packet boundaries come from the configured length only.
  assign unused_tlast  = S_AXIS_TLAST;

  assign len_d         = (cfg_payload_len == '0) ? LEN_W'(1) : cfg_payload_len;
  assign out_free      = !tvalid_q || M_AXIS_TREADY;
  assign S_AXIS_TREADY = (state_q == PAYLOAD) && out_free;
  assign in_fire       = S_AXIS_TREADY && S_AXIS_TVALID;
  assign last_beat     = (beat_cnt_q == len_q - LEN_W'(1));
  assign pkt_size      = (16'(len_q) << 1) + HDR_WRDS;
  assign hdr_word      = {4'b0001, 1'b0, 1'b0, 2'b00, 2'b00, TSF, pkt_cnt_q, pkt_size, strm_id_q};

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = 8'hFF;
  assign stat_pkts     = stat_q;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= IDLE;
      strm_id_q  <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      stat_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
`ifdef VITA49_PACKER_TSF_EN
      samp_cnt_q <= '0;
      ts_q       <= '0;
`endif
    end else begin
      // A consumed beat drains unless one of the states below reloads it.
      if (out_free) tvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_enable && S_AXIS_TVALID) begin
            state_q   <= HDR;
            strm_id_q <= cfg_strm_id;
            len_q     <= len_d;
`ifdef VITA49_PACKER_TSF_EN
            ts_q      <= samp_cnt_q;
`endif
          end
        end
        HDR: begin
          if (out_free) begin
            tdata_q    <= hdr_word;
            tvalid_q   <= 1'b1;
            tlast_q    <= 1'b0;
            beat_cnt_q <= '0;
`ifdef VITA49_PACKER_TSF_EN
            state_q    <= TS;
`else
            state_q    <= PAYLOAD;
`endif
          end
        end
`ifdef VITA49_PACKER_TSF_EN
        TS: begin
          if (out_free) begin
            tdata_q  <= ts_q;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state_q  <= PAYLOAD;
          end
        end
`endif
        PAYLOAD: begin
          if (in_fire) begin
            tdata_q    <= S_AXIS_TDATA;
            tvalid_q   <= 1'b1;
            tlast_q    <= last_beat;
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            if (last_beat) begin
              pkt_cnt_q <= pkt_cnt_q + 4'd1;
              stat_q    <= stat_q + 32'd1;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef VITA49_PACKER_TSF_EN
      if (in_fire) samp_cnt_q <= samp_cnt_q + 64'd1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vita49_packer.sv
`default_nettype none
// =============================================================================
// tb_vita49_packer: table-driven packet vectors plus hand-written corner cases.
// Rev 1.0
// =============================================================================
module tb_vita49_packer;

  logic        clk;
  logic        AXIS_ARESETN;
  logic        cfg_enable;
  logic [31:0] cfg_strm_id;
  logic [11:0] cfg_payload_len;
  logic [63:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic [7:0]  M_AXIS_TSTRB;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic [31:0] stat_pkts;
  logic        busy;

  vita49_packer #(.LEN_W(12)) dut (
    .AXIS_ACLK       (clk),
    .AXIS_ARESETN    (AXIS_ARESETN),
    .cfg_enable      (cfg_enable),
    .cfg_strm_id     (cfg_strm_id),
    .cfg_payload_len (cfg_payload_len),
    .S_AXIS_TDATA    (S_AXIS_TDATA),
    .S_AXIS_TVALID   (S_AXIS_TVALID),
    .S_AXIS_TLAST    (S_AXIS_TLAST),
    .S_AXIS_TREADY   (S_AXIS_TREADY),
    .M_AXIS_TDATA    (M_AXIS_TDATA),
    .M_AXIS_TVALID   (M_AXIS_TVALID),
    .M_AXIS_TSTRB    (M_AXIS_TSTRB),
    .M_AXIS_TLAST    (M_AXIS_TLAST),
    .M_AXIS_TREADY   (M_AXIS_TREADY),
    .stat_pkts       (stat_pkts),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VITA49_PACKER_TSF_EN
  localparam logic [31:0] H0 = 32'h1010000C, H1 = 32'h10110006, H2 = 32'h10120006,
                          H3 = 32'h10130020, HR = 32'h10140014;
`else
  localparam logic [31:0] H0 = 32'h1000000A, H1 = 32'h10010004, H2 = 32'h10020004,
                          H3 = 32'h1003001E, HR = 32'h10040012;
`endif

  typedef struct {
    logic [11:0] cfg_len;
    logic [31:0] sid;
    int          npkts;
    logic [63:0] base;
    logic [63:0] first_hdr;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          in_total = 0;
  int          exp_cnt  = 0;
  logic [31:0] exp_stat = '0;
  logic [63:0] exp_samp = '0;
  bit          rand_mode = 1'b0;
  logic [63:0] src_q[$];
  logic [64:0] out_q[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [63:0] hdr(input int cnt, input int len, input logic [31:0] sid);
    logic [15:0] sz;
    logic [1:0]  tsf;
    logic [3:0]  c;
    c = 4'(cnt);
`ifdef VITA49_PACKER_TSF_EN
    sz  = 16'(4 + 2 * len);
    tsf = 2'b01;
`else
    sz  = 16'(2 + 2 * len);
    tsf = 2'b00;
`endif
    return {4'b0001, 4'b0000, 2'b00, tsf, c, sz, sid};
  endfunction

  // Source: pops a sample once the handshake seen on the preceding low phase completes.
  initial begin
    bit in_acc;
    bit vld;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(negedge clk);
      in_acc = S_AXIS_TVALID && S_AXIS_TREADY;
      @(posedge clk);
      #1;
      if (in_acc && src_q.size() > 0) void'(src_q.pop_front());
      if (rand_mode) begin
        M_AXIS_TREADY = 1'($urandom_range(0, 1));
        vld           = 1'($urandom_range(0, 1));
      end else begin
        M_AXIS_TREADY = 1'b1;
        vld           = 1'b1;
      end
      S_AXIS_TVALID = vld && (src_q.size() > 0);
      S_AXIS_TDATA  = (src_q.size() > 0) ? src_q[0] : 64'd0;
      S_AXIS_TLAST  = ~S_AXIS_TLAST;
    end
  end

  // Output monitor with hold-under-backpressure check.
  initial begin
    bit          prev_stall;
    logic [64:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (AXIS_ARESETN) begin
        if (M_AXIS_TVALID && prev_stall) check("hold", {M_AXIS_TLAST, M_AXIS_TDATA}, prev_beat);
        if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
        if (S_AXIS_TVALID && S_AXIS_TREADY) in_total++;
        prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_beat  = {M_AXIS_TLAST, M_AXIS_TDATA};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int budget, input bit need_empty, input string name);
    int n = 0;
    while (!((!need_empty || src_q.size() == 0) && !busy && !M_AXIS_TVALID) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 65'(M_AXIS_TVALID), 65'd0);
    check({tag, "_tlast"},  65'(M_AXIS_TLAST),  65'd0);
    check({tag, "_tdata"},  65'(M_AXIS_TDATA),  65'd0);
    check({tag, "_sready"}, 65'(S_AXIS_TREADY), 65'd0);
    check({tag, "_stat"},   65'(stat_pkts),     65'd0);
    check({tag, "_busy"},   65'(busy),          65'd0);
  endtask

  task automatic run_packets(input logic [11:0] cl, input logic [31:0] sid, input int npk,
                             input logic [63:0] base, input bit rnd, input logic [63:0] first_hdr);
    int          len;
    logic [64:0] exq[$];
    logic [63:0] d;
    len = (cl == 12'd0) ? 1 : int'(cl);
    d   = base;
    for (int p = 0; p < npk; p++) begin
      exq.push_back({1'b0, hdr(exp_cnt, len, sid)});
`ifdef VITA49_PACKER_TSF_EN
      exq.push_back({1'b0, exp_samp});
`endif
      for (int k = 0; k < len; k++) begin
        exq.push_back({(k == len - 1), d});
        d = d + 64'd1;
      end
      exp_cnt  = (exp_cnt + 1) % 16;
      exp_samp = exp_samp + 64'(len);
      exp_stat = exp_stat + 32'd1;
    end
    out_q.delete();
    rand_mode       = rnd;
    cfg_payload_len = cl;
    cfg_strm_id     = sid;
    cfg_enable      = 1'b1;
    for (int i = 0; i < npk * len; i++) src_q.push_back(base + 64'(i));
    wait_done(400 + npk * len * 16, 1'b1, "timeout_pkts");
    rand_mode = 1'b0;
    check("beat_count", 65'(out_q.size()), 65'(exq.size()));
    for (int i = 0; i < exq.size() && i < out_q.size(); i++)
      check($sformatf("beat%0d", i), out_q[i], exq[i]);
    if (out_q.size() > 0) check("first_hdr", {1'b0, out_q[0][63:0]}, {1'b0, first_hdr});
    check("stat_pkts", 65'(stat_pkts), 65'(exp_stat));
  endtask

  initial begin
    vec_t tbl[4];
    int   start;
    int   n;
    tbl[0] = '{12'd4,  32'hDEADBEEF, 1,  64'd1,     {H0, 32'hDEADBEEF}};
    tbl[1] = '{12'd0,  32'h12345678, 1,  64'h100,   {H1, 32'h12345678}};
    tbl[2] = '{12'd1,  32'h0000CAFE, 17, 64'h200,   {H2, 32'h0000CAFE}};
    tbl[3] = '{12'd14, 32'hAAAA5555, 1,  64'h300,   {H3, 32'hAAAA5555}};

    AXIS_ARESETN    = 1'b0;
    cfg_enable      = 1'b0;
    cfg_strm_id     = '0;
    cfg_payload_len = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst0");
    check("tstrb", 65'(M_AXIS_TSTRB), 65'h0FF);
    AXIS_ARESETN = 1'b1;
    @(posedge clk);
    #2;

    for (int v = 0; v < 4; v++)
      run_packets(tbl[v].cfg_len, tbl[v].sid, tbl[v].npkts, tbl[v].base, 1'b0, tbl[v].first_hdr);

    // Random handshakes on both sides, 100 packets of 8.
    run_packets(12'd8, 32'hC0FFEE00, 100, 64'h1000, 1'b1, {HR, 32'hC0FFEE00});

    // Config change and disable during the 2nd payload beat.
    out_q.delete();
    cfg_payload_len = 12'd4;
    cfg_strm_id     = 32'h0BADF00D;
    cfg_enable      = 1'b1;
    start           = in_total;
    for (int i = 0; i < 8; i++) src_q.push_back(64'd100 + 64'(i));
    n = 0;
    while (in_total < start + 1 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) fail_now("wait_beat2");
    cfg_payload_len = 12'd2;
    cfg_enable      = 1'b0;
    wait_done(200, 1'b0, "timeout_drop");
    repeat (5) @(posedge clk);
    #2;
    check("drop_beats", 65'(out_q.size()), 65'd5);
    check("drop_busy", 65'(busy), 65'd0);
    check("drop_left", 65'(src_q.size()), 65'd4);
    if (out_q.size() == 5) begin
      check("drop_hdr", out_q[0], {1'b0, hdr(exp_cnt, 4, 32'h0BADF00D)});
      for (int k = 0; k < 4; k++)
        check($sformatf("drop_pay%0d", k), out_q[1 + k], {(k == 3), 64'd100 + 64'(k)});
    end
    exp_cnt  = (exp_cnt + 1) % 16;
    exp_stat = exp_stat + 32'd1;
    exp_samp = exp_samp + 64'd4;
    check("drop_stat", 65'(stat_pkts), 65'(exp_stat));
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;

    // Reset in the middle of a payload.
    out_q.delete();
    cfg_enable = 1'b1;
    start      = in_total;
    for (int i = 0; i < 4; i++) src_q.push_back(64'h400 + 64'(i));
    n = 0;
    while (in_total < start + 2 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) fail_now("wait_mid");
    AXIS_ARESETN = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    src_q.delete();
    repeat (2) @(posedge clk);
    #2;
    AXIS_ARESETN = 1'b1;
    exp_cnt  = 0;
    exp_stat = '0;
    exp_samp = '0;
    @(posedge clk);
    #2;
    run_packets(12'd4, 32'h13572468, 1, 64'h500, 1'b0, {H0, 32'h13572468});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
